// File: rtl/ct_pkg.sv
// Shared definitions for the ct_* streaming blocks: the merge FSM state
// encoding and the CLogB2 width helper used to size channel indices.
package ct_pkg;

  // Largest channel count the merge is intended to be built with.
  localparam int CT_MAX_NI = 16;

  // Merge controller states: IDLE arbitrates, LOCK streams one packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } ct_state_e;

  // Bits needed to index n items, never less than one so that a
  // single-channel build still has a usable index signal.
  function automatic int CLogB2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_rr_arb.sv
// Combinational round-robin pick: starting just after the channel that
// finished last, return the first requesting channel and whether any
// channel requested at all.
module ct_rr_arb
  import ct_pkg::*;
#(
  parameter int NI     = 2,
  parameter int NIBITS = CLogB2(NI)
) (
  input  logic [NI-1:0]     req_i,
  input  logic [NIBITS-1:0] last_i,
  output logic [NIBITS-1:0] grant_o,
  output logic              any_o
);

  int                idx_w;
  logic [NIBITS-1:0] cand;

  // Scan last+1, last+2, ... (mod NI) and keep the first requester found.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx_w   = 0;
    cand    = '0;
    for (int i = 1; i <= NI; i++) begin
      idx_w = (int'(last_i) + i) % NI;
      cand  = NIBITS'(idx_w);
      if (!any_o && req_i[cand]) begin
        grant_o = cand;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ct_merge_rr.sv
// Packet-level round-robin merge of NI cut-through streams into one.
// A channel is granted in an arbitration cycle (IDLE, no input ready) and
// keeps the grant until its end-of-packet beat is accepted.
// Optional build macro CT_MERGE_RR_SKID_EN: replaces the single output
// register with a 2-entry skid buffer so the upstream ready no longer
// depends combinationally on i_ready.
module ct_merge_rr
  import ct_pkg::*;
#(
  parameter int  NI     = 2,
  parameter int  WIDTH  = 32,
  localparam int NIBITS = CLogB2(NI)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NI*WIDTH-1:0] i_data,
  input  logic [NI-1:0]       i_valid,
  input  logic [NI-1:0]       i_eop,
  output logic [NI-1:0]       o_ready,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_valid,
  output logic                o_eop,
  output logic [NIBITS-1:0]   o_src,
  input  logic                i_ready
);

  ct_state_e         state_q;
  logic [NIBITS-1:0] grant_q;
  logic [NIBITS-1:0] last_q;

  logic [NIBITS-1:0] arb_grant;
  logic              arb_any;

  logic [WIDTH-1:0]  sel_data;
  logic              sel_valid;
  logic              sel_eop;

  // Output slot can take a beat this cycle.
  logic              slot_ok;
  // Beat moves from the granted channel into the output stage.
  logic              accept;

  ct_rr_arb #(
    .NI     (NI),
    .NIBITS (NIBITS)
  ) u_arb (
    .req_i   (i_valid),
    .last_i  (last_q),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Route the granted channel's beat and flags toward the output stage.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_eop   = 1'b0;
    for (int k = 0; k < NI; k++) begin
      if (grant_q == NIBITS'(k)) begin
        sel_data  = i_data[k*WIDTH +: WIDTH];
        sel_valid = i_valid[k];
        sel_eop   = i_eop[k];
      end
    end
  end

  // Only the granted channel sees ready, and only while locked with room.
  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NI; k++) begin
      o_ready[k] = (state_q == LOCK) && slot_ok && (grant_q == NIBITS'(k));
    end
  end

  assign accept = (state_q == LOCK) && slot_ok && sel_valid;

  // Grant FSM: pick a channel when idle, release it on its end-of-packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= NIBITS'(NI - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (accept && sel_eop) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CT_MERGE_RR_SKID_EN

  // Two-entry buffer: head drives the outputs, spare catches the beat
  // that arrives while the head is blocked downstream.
  logic [1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  head_data_q, head_data_d;
  logic              head_eop_q, head_eop_d;
  logic [NIBITS-1:0] head_src_q, head_src_d;
  logic              head_vld_q;
  logic [WIDTH-1:0]  spare_data_q, spare_data_d;
  logic              spare_eop_q, spare_eop_d;
  logic [NIBITS-1:0] spare_src_q, spare_src_d;
  logic              pop;

  // Ready comes from stored occupancy only, so it never sees i_ready.
  assign slot_ok = (cnt_q != 2'd2);
  assign pop     = head_vld_q && i_ready;

  // Next buffer contents for every push/pop combination.
  always_comb begin
    cnt_d        = cnt_q;
    head_data_d  = head_data_q;
    head_eop_d   = head_eop_q;
    head_src_d   = head_src_q;
    spare_data_d = spare_data_q;
    spare_eop_d  = spare_eop_q;
    spare_src_d  = spare_src_q;
    case ({accept, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_data_d = sel_data;
          head_eop_d  = sel_eop;
          head_src_d  = grant_q;
        end else begin
          spare_data_d = sel_data;
          spare_eop_d  = sel_eop;
          spare_src_d  = grant_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          head_data_d = spare_data_q;
          head_eop_d  = spare_eop_q;
          head_src_d  = spare_src_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          head_data_d  = spare_data_q;
          head_eop_d   = spare_eop_q;
          head_src_d   = spare_src_q;
          spare_data_d = sel_data;
          spare_eop_d  = sel_eop;
          spare_src_d  = grant_q;
        end else begin
          head_data_d = sel_data;
          head_eop_d  = sel_eop;
          head_src_d  = grant_q;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; reset drops any held beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= 2'd0;
      head_vld_q   <= 1'b0;
      head_data_q  <= '0;
      head_eop_q   <= 1'b0;
      head_src_q   <= '0;
      spare_data_q <= '0;
      spare_eop_q  <= 1'b0;
      spare_src_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      head_vld_q   <= (cnt_d != 2'd0);
      head_data_q  <= head_data_d;
      head_eop_q   <= head_eop_d;
      head_src_q   <= head_src_d;
      spare_data_q <= spare_data_d;
      spare_eop_q  <= spare_eop_d;
      spare_src_q  <= spare_src_d;
    end
  end

  assign o_data  = head_data_q;
  assign o_valid = head_vld_q;
  assign o_eop   = head_eop_q;
  assign o_src   = head_src_q;

`else

  logic [WIDTH-1:0]  out_data_q;
  logic              out_vld_q;
  logic              out_eop_q;
  logic [NIBITS-1:0] out_src_q;

  // Single slot: refill when empty or when its beat leaves this cycle.
  assign slot_ok = !out_vld_q || i_ready;

  // Output register: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_src_q  <= '0;
    end else if (accept) begin
      out_data_q <= sel_data;
      out_vld_q  <= 1'b1;
      out_eop_q  <= sel_eop;
      out_src_q  <= grant_q;
    end else if (i_ready) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign o_data  = out_data_q;
  assign o_valid = out_vld_q;
  assign o_eop   = out_eop_q;
  assign o_src   = out_src_q;

`endif

endmodule

// File: tb/tb_ct_merge_rr.sv
// Bench for ct_merge_rr: per-channel packet queues feed the DUT, a
// packet-level round-robin model predicts which channel may be ready, and a
// monitor process checks every output beat against the channel's queue.
module tb_ct_merge_rr;
  import ct_pkg::*;

  localparam int NI    = 4;
  localparam int WIDTH = 16;
  localparam int NIB   = CLogB2(NI);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                o_eop;
  logic [NIB-1:0]      o_src;
  logic                i_ready;

  ct_merge_rr #(.NI(NI), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_eop   (i_eop),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_eop   (o_eop),
    .o_src   (o_src),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             eop;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t drv_q[NI][$];
  beat_t exp_q[NI][$];

  int n_checks = 0;
  int n_fail   = 0;

  int vprob = 100, rprob = 100, lmax = 1, hold = 0, gen_pct = 0;
  bit gen_on = 1'b0, rand_hold = 1'b0;
  bit [NI-1:0] drop = '0;

  bit locked = 1'b0;
  int g = 0;
  int last = NI - 1;
  int acc_total = 0, xfer_total = 0;

  bit rec = 1'b0;
  int seq_q[$];
  int tseq_q[$];
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NI-1:0] v, input int l);
    for (int i = 1; i <= NI; i++) begin
      if (v[(l + i) % NI]) return (l + i) % NI;
    end
    return -1;
  endfunction

  task automatic load_pkt(input int k, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = WIDTH'($urandom);
      b.eop  = (i == len - 1);
      drv_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
  endtask

  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < NI; k++) n += drv_q[k].size();
    return n;
  endfunction

  // One clock of stimulus plus the input-side model.
  task automatic cycle();
    logic [NI-1:0] v;
    logic [NI-1:0] orv;
    beat_t b;
    @(negedge clk);
    if (gen_on) begin
      for (int k = 0; k < NI; k++) begin
        if (drv_q[k].size() == 0 && ($urandom % 100) < gen_pct)
          load_pkt(k, 1 + int'($urandom % lmax));
      end
    end
    v = '0;
    for (int k = 0; k < NI; k++) begin
      v[k] = (drv_q[k].size() != 0) && !drop[k] && (($urandom % 100) < vprob);
      if (drv_q[k].size() != 0) begin
        i_data[k*WIDTH +: WIDTH] = drv_q[k][0].data;
        i_eop[k] = drv_q[k][0].eop;
      end else begin
        i_data[k*WIDTH +: WIDTH] = '0;
        i_eop[k] = 1'b0;
      end
    end
    i_valid = v;
    if (hold > 0) begin
      i_ready = 1'b0;
      hold--;
    end else begin
      i_ready = (($urandom % 100) < rprob);
      if (rand_hold && ($urandom % 100) < 2) hold = 5;
    end
    #1;
    orv = o_ready;
    chk("o_ready_onehot", 64'($onehot0(orv)), 1);
    chk("o_valid_occupancy", o_valid, 64'(acc_total != xfer_total));
    if (!locked) begin
      chk("o_ready_arb_cycle", orv, 0);
      if (v != '0) begin
        g = rr_pick(v, last);
        locked = 1'b1;
      end
    end else begin
      chk("o_ready_grant_only", orv & ~(NI'(1) << g), 0);
`ifdef CT_MERGE_RR_SKID_EN
      chk("o_ready_skid", orv[g], 64'((acc_total - xfer_total) < 2));
`else
      chk("o_ready_slot", orv[g], 64'((acc_total == xfer_total) || i_ready));
`endif
      if (v[g] && orv[g]) begin
        b = drv_q[g].pop_front();
        acc_total++;
        if (b.eop) begin
          last = g;
          locked = 1'b0;
        end
      end
    end
`ifdef CT_MERGE_RR_SKID_EN
    #2;
    i_ready = !i_ready;
    #1;
    chk("o_ready_indep_of_i_ready", o_ready, orv);
    i_ready = !i_ready;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_valid = '0;
    i_eop = '0;
    i_data = '0;
    i_ready = 1'b1;
    hold = 0;
    drop = '0;
    for (int k = 0; k < NI; k++) begin
      drv_q[k].delete();
      exp_q[k].delete();
    end
    locked = 1'b0;
    last = NI - 1;
    acc_total = 0;
    xfer_total = 0;
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_eop", o_eop, 0);
    chk("reset_o_data", o_data, 0);
    chk("reset_o_src", o_src, 0);
    chk("reset_o_ready", o_ready, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_seq(input string nm, input int e[$]);
    for (int i = 0; i < e.size(); i++) begin
      if (i < seq_q.size()) begin
        chk(nm, seq_q[i], e[i]);
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: output beat %0d missing, expected src %0d", nm, i, e[i]);
      end
    end
  endtask

  task automatic start_rec();
    seq_q.delete();
    tseq_q.delete();
    rec = 1'b1;
  endtask

  // Output monitor: scoreboard pop, hold stability and packet contiguity.
  int    m_src;
  beat_t m_exp;
  bit    m_held = 1'b0;
  logic [WIDTH+NIB:0] m_held_v;
  bit    m_prev_eop = 1'b1;
  int    m_prev_src = 0;

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      m_held = 1'b0;
      m_prev_eop = 1'b1;
    end else begin
      if (m_held) begin
        chk("hold_o_valid", o_valid, 1);
        chk("hold_o_beat", {o_eop, o_src, o_data}, m_held_v);
      end
      m_held = o_valid && !i_ready;
      m_held_v = {o_eop, o_src, o_data};
      if (o_valid && i_ready) begin
        xfer_total++;
        m_src = int'(o_src);
        if (rec) begin
          seq_q.push_back(m_src);
          tseq_q.push_back(cyc);
        end
        if (!m_prev_eop) chk("no_interleave", m_src, m_prev_src);
        if (m_src >= NI || exp_q[m_src].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: src %0d data %0h with no pending beat", m_src, o_data);
        end else begin
          m_exp = exp_q[m_src].pop_front();
          chk("out_beat", {o_eop, o_data}, m_exp);
        end
        m_prev_eop = o_eop;
        m_prev_src = m_src;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ex[$];
    int guard;
    i_valid = '0;
    i_eop = '0;
    i_data = '0;
    i_ready = 1'b1;

    // All channels valid with single-beat packets.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NI; k++) load_pkt(k, 1);
    start_rec();
    repeat (24) cycle();
    rec = 1'b0;
    ex = {0, 1, 2, 3, 0};
    check_seq("rr_order", ex);
    chk("rr_bubble_gap", (tseq_q.size() >= 2) ? 64'(tseq_q[1] - tseq_q[0]) : 64'hFFFF, 2);

    // Channel 2 three-beat packet while channel 0 waits.
    do_reset();
    load_pkt(1, 1);
    repeat (4) cycle();
    start_rec();
    load_pkt(2, 3);
    load_pkt(0, 1);
    repeat (12) cycle();
    rec = 1'b0;
    ex = {2, 2, 2, 0};
    check_seq("multi_beat_lock", ex);

    // Downstream stall of 5 cycles mid-packet.
    do_reset();
    load_pkt(0, 6);
    start_rec();
    repeat (3) cycle();
    hold = 5;
    repeat (16) cycle();
    rec = 1'b0;
    ex = {0, 0, 0, 0, 0, 0};
    check_seq("stall_no_loss", ex);
    chk("accepts_eq_transfers", acc_total, xfer_total);

    // Channel 1 drops valid mid-packet while channel 3 is valid.
    do_reset();
    load_pkt(1, 4);
    load_pkt(3, 2);
    start_rec();
    repeat (2) cycle();
    drop[1] = 1'b1;
    repeat (2) cycle();
    drop = '0;
    repeat (14) cycle();
    rec = 1'b0;
    ex = {1, 1, 1, 1, 3, 3};
    check_seq("valid_drop_keeps_grant", ex);

    // Reset during the second beat of a packet.
    do_reset();
    load_pkt(2, 3);
    repeat (2) cycle();
    do_reset();
    for (int k = 0; k < NI; k++) load_pkt(k, 1);
    start_rec();
    repeat (12) cycle();
    rec = 1'b0;
    ex = {0, 1, 2, 3};
    check_seq("after_midpkt_reset", ex);

    // Random traffic, random backpressure and valid gaps.
    do_reset();
    gen_on = 1'b1;
    gen_pct = 30;
    lmax = 5;
    vprob = 75;
    rprob = 50;
    rand_hold = 1'b1;
    repeat (3000) cycle();
    gen_on = 1'b0;
    rand_hold = 1'b0;
    vprob = 100;
    rprob = 100;
    guard = 0;
    while ((pending() != 0 || acc_total != xfer_total || locked) && guard < 400) begin
      cycle();
      guard++;
    end
    chk("drain_within_budget", 64'(guard < 400), 1);
    repeat (2) cycle();
    guard = 0;
    for (int k = 0; k < NI; k++) guard += exp_q[k].size();
    chk("scoreboard_empty", guard, 0);
    chk("final_accepts_eq_transfers", acc_total, xfer_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
